// File: rtl/inst_uart_loader.sv
// inst_uart_loader: receives a UART program image (BE word count, then BE words)
// and writes it word-by-word into the instruction BRAM while the core is in LOAD mode.
module inst_uart_loader #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int ADDR_W           = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [2:0]        mode,
  input  logic              rxd,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic [31:0]       word_count,
  output logic              done,
  output logic              err
);
  localparam int          TW    = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLK_PER_HALF_BIT - 1);
  localparam logic [TW-1:0] FULL = TW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;
  localparam logic [2:0]  LOAD  = 3'd1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_WAIT, LD_HEADER, LD_PAYLOAD, LD_FINISH} ld_state_t;

  rx_state_t         rx_state_q, rx_state_d;
  ld_state_t         ld_state_q, ld_state_d;
  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              byte_valid_q, byte_valid_d;
  logic              ferr, tick;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_count_q, word_count_d, wdata_q, wdata_d, hdr_n;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              we_q, we_d, done_q, done_d, err_q, err_d;

  assign tick  = (tmr_q == '0);
  assign hdr_n = {word_count_q[23:0], shreg_q};

  always_comb begin
    rx_state_d   = rx_state_q;
    tmr_d        = tmr_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    ferr         = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_state_d = RX_START;
        tmr_d      = HALF;
      end
      RX_START: if (tick) begin
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        tmr_d      = FULL;
        bit_cnt_d  = 3'd0;
      end else tmr_d = tmr_q - TW'(1);
      RX_DATA: if (tick) begin
        shreg_d    = {rx_sync_q, shreg_q[7:1]};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        tmr_d      = FULL;
        rx_state_d = (bit_cnt_q == 3'd7) ? RX_STOP : RX_DATA;
      end else tmr_d = tmr_q - TW'(1);
      RX_STOP: if (tick) begin
        byte_valid_d = rx_sync_q;
        ferr         = !rx_sync_q;
        rx_state_d   = RX_IDLE;
      end else tmr_d = tmr_q - TW'(1);
    endcase
  end

  always_comb begin
    ld_state_d   = ld_state_q;
    byte_idx_d   = byte_idx_q;
    word_count_d = word_count_q;
    wdata_d      = wdata_q;
    waddr_d      = waddr_q;
    we_d         = 1'b0;
    err_d        = err_q | ferr;
    case (ld_state_q)
      LD_WAIT: if (mode == LOAD) begin
        ld_state_d = LD_HEADER;
        byte_idx_d = 2'd0;
      end
      LD_HEADER: if (mode != LOAD) begin
        ld_state_d = LD_WAIT;
        byte_idx_d = 2'd0;
      end else if (byte_valid_q) begin
        word_count_d = hdr_n;
        byte_idx_d   = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          if (hdr_n == '0) ld_state_d = LD_FINISH;
          else if ({1'b0, hdr_n} > DEPTH) begin
            err_d      = 1'b1;
            ld_state_d = LD_FINISH;
          end else begin
            ld_state_d = LD_PAYLOAD;
            waddr_d    = '0;
          end
        end
      end
      LD_PAYLOAD: if (mode != LOAD) begin
        ld_state_d = LD_WAIT;
        byte_idx_d = 2'd0;
        wdata_d    = '0;
      end else if (we_q) begin
        // the final word leaves waddr pointing at itself
        if (32'(waddr_q) == word_count_q - 32'd1) ld_state_d = LD_FINISH;
        else waddr_d = waddr_q + ADDR_W'(1);
      end else if (byte_valid_q) begin
        wdata_d    = {wdata_q[23:0], shreg_q};
        byte_idx_d = byte_idx_q + 2'd1;
        we_d       = (byte_idx_q == 2'd3);
      end
      LD_FINISH: ld_state_d = LD_FINISH;
    endcase
    done_d = done_q | (ld_state_d == LD_FINISH);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      tmr_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      ld_state_q   <= LD_WAIT;
      byte_idx_q   <= '0;
      word_count_q <= '0;
      wdata_q      <= '0;
      waddr_q      <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_meta_q    <= rxd;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      tmr_q        <= tmr_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      ld_state_q   <= ld_state_d;
      byte_idx_q   <= byte_idx_d;
      word_count_q <= word_count_d;
      wdata_q      <= wdata_d;
      waddr_q      <= waddr_d;
      we_q         <= we_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign word_count = word_count_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_inst_uart_loader.sv
// tb_inst_uart_loader: directed UART images with a write scoreboard for inst_uart_loader.
module tb_inst_uart_loader;
  logic        clk = 1'b0, rstn = 1'b0, rxd = 1'b1;
  logic [2:0]  mode = 3'd0;
  logic        we, done, err;
  logic [3:0]  waddr;
  logic [31:0] wdata, word_count;
  int          total = 0, bad = 0, rd = 0;
  logic [3:0]  obs_a[$];
  logic [31:0] obs_d[$];
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  inst_uart_loader #(.CLK_PER_HALF_BIT(4), .ADDR_W(4)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .rxd(rxd), .we(we), .waddr(waddr),
    .wdata(wdata), .word_count(word_count), .done(done), .err(err)
  );

  always @(negedge clk) if (we) begin
    obs_a.push_back(waddr);
    obs_d.push_back(wdata);
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    idle(8);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(8);
    end
    rxd = stop;
    idle(8);
    rxd = 1'b1;
    idle(8);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8], 1'b1);
  endtask

  task automatic expw(input logic [3:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic rst(input logic [2:0] m);
    rstn = 1'b0;
    mode = m;
    rxd  = 1'b1;
    idle(3);
    rstn = 1'b1;
  endtask

  task automatic check_writes(input string tag);
    logic [35:0] e;
    chk({tag, " nwrites"}, obs_a.size() - rd, exp_q.size());
    while (rd < obs_a.size() && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " waddr"}, obs_a[rd], e[35:32]);
      chk({tag, " wdata"}, obs_d[rd], e[31:0]);
      rd++;
    end
    rd = obs_a.size();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] w;
    rst(3'd1);
    expw(4'd0, 32'h12345678);
    expw(4'd1, 32'hDEADBEEF);
    send_word(32'd2);
    send_word(32'h12345678);
    idle(20);
    chk("s1 done before last", done, 0);
    chk("s1 waddr after first", waddr, 1);
    send_word(32'hDEADBEEF);
    idle(20);
    check_writes("s1");
    chk("s1 word_count", word_count, 2);
    chk("s1 done", done, 1);
    chk("s1 err", err, 0);
    chk("s1 waddr final", waddr, 1);

    rstn = 1'b0;
    idle(2);
    chk("rst we", we, 0);
    chk("rst waddr", waddr, 0);
    chk("rst wdata", wdata, 0);
    chk("rst word_count", word_count, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    rstn = 1'b1;

    rst(3'd1);
    send_word(32'd0);
    idle(20);
    check_writes("s2 zero");
    chk("s2 done", done, 1);
    chk("s2 err", err, 0);

    rst(3'd1);
    send_word(32'h11);
    idle(20);
    check_writes("s3 overflow");
    chk("s3 err", err, 1);
    chk("s3 done", done, 1);
    chk("s3 word_count", word_count, 17);

    rst(3'd1);
    send_word(32'd16);
    for (int i = 0; i < 16; i++) begin
      w = (32'(i) * 32'h01010101) ^ 32'hA5000000;
      expw(4'(i), w);
      send_word(w);
    end
    idle(20);
    check_writes("s3b full depth");
    chk("s3b err", err, 0);
    chk("s3b done", done, 1);
    chk("s3b waddr", waddr, 15);

    rst(3'd1);
    send(8'h55, 1'b0);
    idle(4);
    chk("s4 framing err", err, 1);
    expw(4'd0, 32'hCAFEBABE);
    send_word(32'd1);
    send_word(32'hCAFEBABE);
    idle(20);
    check_writes("s4");
    chk("s4 done", done, 1);
    chk("s4 word_count", word_count, 1);
    chk("s4 err sticky", err, 1);

    rst(3'd1);
    send_word(32'd2);
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    mode = 3'd2;
    idle(10);
    check_writes("s5 abort");
    chk("s5 done after abort", done, 0);
    send(8'h56, 1'b1);
    mode = 3'd1;
    idle(4);
    expw(4'd0, 32'hAABBCCDD);
    expw(4'd1, 32'h11223344);
    send_word(32'd2);
    send_word(32'hAABBCCDD);
    send_word(32'h11223344);
    idle(20);
    check_writes("s5 reload");
    chk("s5 done", done, 1);
    chk("s5 err", err, 0);
    chk("s5 waddr", waddr, 1);

    rst(3'd1);
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(20);
    expw(4'd0, 32'h0BADF00D);
    send_word(32'd1);
    send_word(32'h0BADF00D);
    idle(20);
    check_writes("s6 glitch");
    chk("s6 err", err, 0);
    chk("s6 done", done, 1);

    rst(3'd0);
    send_word(32'd1);
    send_word(32'h13579BDF);
    idle(20);
    check_writes("s7 mode0");
    chk("s7 err", err, 0);
    chk("s7 done", done, 0);
    chk("s7 word_count", word_count, 0);
    mode = 3'd1;
    idle(4);
    expw(4'd0, 32'h2468ACE0);
    send_word(32'd1);
    send_word(32'h2468ACE0);
    idle(20);
    check_writes("s7 load");
    chk("s7 done after load", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
